// File: rtl/pcap_frame_capture.sv
// Position-capture core: snapshots the position bus on capture edges and serialises a programmable
// list of value / frame-delta / timestamp words into a first-word-fall-through valid/ready FIFO.
module pcap_frame_capture #(
  parameter int NCHAN      = 32,
  parameter int LIST_DEPTH = 64,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                ARM,
  input  logic                DISARM,
  input  logic                START_WRITE,
  input  logic [31:0]         WRITE,
  input  logic                WRITE_WSTB,
  input  logic                enable_i,
  input  logic                capture_i,
  input  logic                frame_i,
  input  logic [NCHAN*32-1:0] posbus_i,
  output logic [31:0]         pcap_dat_o,
  output logic                pcap_dat_valid_o,
  input  logic                pcap_dat_ready_i,
  output logic                pcap_actv_o,
  output logic                pcap_done_o,
  output logic [1:0]          HEALTH
);
  localparam int LW = $clog2(LIST_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;
  state_e state_q, state_d;

  logic [9:0]  list_mem [LIST_DEPTH];
  logic [31:0] fifo_mem [FIFO_DEPTH];

  logic [NCHAN-1:0][31:0] bus;
  logic [NCHAN-1:0][31:0] snap_q, snap_d, snap_lat_q, snap_lat_d, frame_lat_q, frame_lat_d;
  logic [63:0] ts_q, ts_d, snap_ts_q, snap_ts_d;
  logic [LW:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic        busy_q, busy_d;
  logic [FW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW:0]   count_q, count_d;
  logic [1:0]  health_q, health_d;
  logic        done_q, done_d;
  logic        capture_q, frame_q, enable_q;

  logic        cap_edge, frame_edge, en_fall, arm_go, capture_go, overrun, overflow;
  logic        fifo_full, fifo_we, fifo_re, list_we, last_entry, chan_ok;
  logic [9:0]  entry;
  logic [7:0]  chan;
  logic [31:0] chan_val, chan_lat, word;
  logic        unused_write_bits;

  assign bus               = posbus_i;
  assign unused_write_bits = ^WRITE[31:10];

  assign cap_edge   = capture_i & ~capture_q;
  assign frame_edge = frame_i & ~frame_q;
  assign en_fall    = enable_q & ~enable_i;
  assign arm_go     = ARM && (state_q == IDLE);
  assign capture_go = (state_q == ACTIVE) && enable_i && cap_edge && (len_q != '0);
  assign overrun    = capture_go && busy_q;
  assign fifo_full  = (count_q == (FW+1)'(FIFO_DEPTH));
  assign overflow   = busy_q && fifo_full;
  assign fifo_we    = busy_q && !fifo_full;
  assign fifo_re    = (count_q != '0) && pcap_dat_ready_i;
  assign last_entry = (({1'b0, idx_q} + (LW+1)'(1)) == len_q);

  // Word for the current list entry, built from the frozen snapshot.
  assign entry    = list_mem[idx_q];
  assign chan     = entry[7:0];
  assign chan_ok  = (32'(chan) < NCHAN);
  assign chan_val = chan_ok ? snap_q[chan[CW-1:0]] : '0;
  assign chan_lat = chan_ok ? snap_lat_q[chan[CW-1:0]] : '0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    word = chan_val;
    case (entry[9:8])
      2'd1:    word = chan_val - chan_lat;
      2'd2:    word = snap_ts_q[31:0];
      2'd3:    word = snap_ts_q[63:32];
      default: word = chan_val;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ARM) state_d = ACTIVE;
      ACTIVE:  if (DISARM || en_fall || overrun || overflow) state_d = DRAIN;
      DRAIN:   if (!busy_q && (count_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pcap_actv_o      = (state_q != IDLE);
    pcap_done_o      = done_q;
    pcap_dat_valid_o = (count_q != '0);
    pcap_dat_o       = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
    HEALTH           = health_q;
  end

  always_comb begin
    len_d       = len_q;
    list_we     = 1'b0;
    busy_d      = busy_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    snap_lat_d  = snap_lat_q;
    snap_ts_d   = snap_ts_q;
    frame_lat_d = frame_lat_q;
    ts_d        = ts_q;
    health_d    = health_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    done_d      = (state_q == DRAIN) && (state_d == IDLE);

    if (state_q == IDLE) begin
      if (START_WRITE) begin
        len_d = '0;
      end else if (WRITE_WSTB && (len_q < (LW+1)'(LIST_DEPTH))) begin
        list_we = 1'b1;
        len_d   = len_q + (LW+1)'(1);
      end
    end

    if (arm_go) begin
      ts_d        = '0;
      frame_lat_d = '0;
      health_d    = 2'd0;
      busy_d      = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end else begin
      if (state_q == ACTIVE) ts_d = ts_q + 64'd1;
      if (frame_edge) frame_lat_d = bus;
      // First error wins; later errors leave HEALTH untouched until the next ARM.
      if (health_q == 2'd0) begin
        if (overrun)                            health_d = 2'd1;
        else if (overflow)                      health_d = 2'd2;
        else if (DISARM && (state_q != IDLE))   health_d = 2'd3;
      end
      if (overflow) begin
        busy_d = 1'b0;
      end else if (fifo_we) begin
        if (last_entry) busy_d = 1'b0;
        else            idx_d  = idx_q + LW'(1);
      end else if (capture_go) begin
        busy_d     = 1'b1;
        idx_d      = '0;
        snap_d     = bus;
        snap_lat_d = frame_lat_q;
        snap_ts_d  = ts_q;
      end
      if (fifo_we) wr_ptr_d = wr_ptr_q + FW'(1);
      if (fifo_re) rd_ptr_d = rd_ptr_q + FW'(1);
      count_d = count_q + (FW+1)'(fifo_we) - (FW+1)'(fifo_re);
    end
  end

  // NOTE: storage arrays carry no reset; len and the FIFO pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (list_we) list_mem[len_q[LW-1:0]] <= WRITE[9:0];
    if (fifo_we) fifo_mem[wr_ptr_q] <= word;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      snap_q      <= '0;
      snap_lat_q  <= '0;
      frame_lat_q <= '0;
      ts_q        <= '0;
      snap_ts_q   <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      health_q    <= 2'd0;
      done_q      <= 1'b0;
      capture_q   <= 1'b0;
      frame_q     <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      snap_lat_q  <= snap_lat_d;
      frame_lat_q <= frame_lat_d;
      ts_q        <= ts_d;
      snap_ts_q   <= snap_ts_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      health_q    <= health_d;
      done_q      <= done_d;
      capture_q   <= capture_i;
      frame_q     <= frame_i;
      enable_q    <= enable_i;
    end
  end
endmodule

// File: tb/tb_pcap_frame_capture.sv
// Scoreboard bench for pcap_frame_capture: stimulus pushes expected words, a negedge monitor
// pops and compares every accepted output word; control/status outputs are checked directly.
module tb_pcap_frame_capture;
  localparam int NCHAN = 32;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic ARM = 1'b0, DISARM = 1'b0, START_WRITE = 1'b0, WRITE_WSTB = 1'b0;
  logic [31:0] WRITE = '0;
  logic enable_i = 1'b1, capture_i = 1'b0, frame_i = 1'b0, pcap_dat_ready_i = 1'b1;
  logic [NCHAN*32-1:0] posbus = '0;
  logic [31:0] pcap_dat_o;
  logic pcap_dat_valid_o, pcap_actv_o, pcap_done_o;
  logic [1:0] HEALTH;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rcvd = 0;
  logic [31:0] exp_q [$];

  pcap_frame_capture #(.NCHAN(NCHAN), .LIST_DEPTH(64), .FIFO_DEPTH(256)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .ARM(ARM), .DISARM(DISARM), .START_WRITE(START_WRITE),
    .WRITE(WRITE), .WRITE_WSTB(WRITE_WSTB), .enable_i(enable_i), .capture_i(capture_i),
    .frame_i(frame_i), .posbus_i(posbus), .pcap_dat_o(pcap_dat_o),
    .pcap_dat_valid_o(pcap_dat_valid_o), .pcap_dat_ready_i(pcap_dat_ready_i),
    .pcap_actv_o(pcap_actv_o), .pcap_done_o(pcap_done_o), .HEALTH(HEALTH)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a word is consumed on the edge after valid & ready is seen here.
  always @(negedge clk_i) begin
    if (!reset_i && pcap_dat_valid_o && pcap_dat_ready_i) begin
      rcvd++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL word: got %0h expected nothing (scoreboard empty)", pcap_dat_o);
      end else begin
        check("word", 64'(pcap_dat_o), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic set_ch(input int n, input logic [31:0] v);
    posbus[n*32 +: 32] = v;
  endtask

  task automatic pulse_arm(output int e);
    ARM = 1'b1; step(1); e = cyc; ARM = 1'b0;
  endtask

  task automatic pulse_disarm();
    DISARM = 1'b1; step(1); DISARM = 1'b0;
  endtask

  task automatic clear_list();
    START_WRITE = 1'b1; step(1); START_WRITE = 1'b0;
  endtask

  task automatic wr(input int ch, input int mode);
    WRITE = {22'd0, 2'(mode), 8'(ch)};
    WRITE_WSTB = 1'b1; step(1); WRITE_WSTB = 1'b0;
  endtask

  task automatic pulse_capture(output int e);
    capture_i = 1'b1; step(1); e = cyc; capture_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (pcap_actv_o && n < max) begin
      step(1);
      n++;
    end
    check({name, " actv"}, 64'(pcap_actv_o), 64'd0);
    check({name, " done"}, 64'(pcap_done_o), 64'd1);
    step(1);
    check({name, " done width"}, 64'(pcap_done_o), 64'd0);
  endtask

  initial begin
    int arm_e, cap_e, r0;

    // Reset state
    step(2);
    check("rst dat", 64'(pcap_dat_o), 64'd0);
    check("rst valid", 64'(pcap_dat_valid_o), 64'd0);
    check("rst actv", 64'(pcap_actv_o), 64'd0);
    check("rst done", 64'(pcap_done_o), 64'd0);
    check("rst health", 64'(HEALTH), 64'd0);
    reset_i = 1'b0;
    step(2);

    // Value, diff, timestamps and an out-of-range channel
    wr(0, 0); wr(3, 1); wr(0, 2); wr(0, 3); wr(40, 0);
    set_ch(0, 32'h11); set_ch(1, 32'h55); set_ch(3, 32'd100); set_ch(8, 32'hDEAD);
    pulse_arm(arm_e);
    frame_i = 1'b1; step(1); frame_i = 1'b0;
    step(2);
    set_ch(0, 32'd7); set_ch(3, 32'd130);
    capture_i = 1'b1; step(1); cap_e = cyc; capture_i = 1'b0;
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd30);
    exp_q.push_back(32'(cap_e - arm_e - 1));
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    step(10);
    check("t1 actv", 64'(pcap_actv_o), 64'd1);
    check("t1 health ok", 64'(HEALTH), 64'd0);
    pulse_disarm();
    check("t1 health disarm", 64'(HEALTH), 64'd3);
    wait_idle("t1", 20);

    // Capture overrun: edges two cycles apart
    clear_list();
    for (int n = 0; n < 4; n++) begin wr(n, 0); set_ch(n, 32'(1000 + n)); end
    pulse_arm(arm_e);
    step(2);
    for (int n = 0; n < 4; n++) exp_q.push_back(32'(1000 + n));
    capture_i = 1'b1; step(1); capture_i = 1'b0;
    for (int n = 0; n < 4; n++) set_ch(n, 32'(2000 + n));
    step(1);
    capture_i = 1'b1; step(1); capture_i = 1'b0;
    check("ovr health", 64'(HEALTH), 64'd1);
    wait_idle("ovr", 50);
    check("ovr health held", 64'(HEALTH), 64'd1);

    // FIFO overflow with the consumer stalled
    pcap_dat_ready_i = 1'b0;
    pulse_arm(arm_e);
    check("ovf health cleared", 64'(HEALTH), 64'd0);
    for (int i = 0; i < 65; i++) begin
      for (int n = 0; n < 4; n++) set_ch(n, 32'(32'h10000 + i * 256 + n));
      if (i < 64)
        for (int n = 0; n < 4; n++) exp_q.push_back(32'(32'h10000 + i * 256 + n));
      pulse_capture(cap_e);
      step(5);
    end
    check("ovf health", 64'(HEALTH), 64'd2);
    check("ovf actv", 64'(pcap_actv_o), 64'd1);
    check("ovf valid", 64'(pcap_dat_valid_o), 64'd1);
    check("ovf head stable", 64'(pcap_dat_o), 64'h10000);
    r0 = rcvd;
    pcap_dat_ready_i = 1'b1;
    wait_idle("ovf", 400);
    check("ovf word count", 64'(rcvd - r0), 64'd256);

    // Simultaneous frame and capture on a DIFF entry
    clear_list();
    wr(1, 1);
    set_ch(1, 32'd5);
    pulse_arm(arm_e);
    exp_q.push_back(32'd5);
    pulse_capture(cap_e);
    step(4);
    set_ch(1, 32'd50);
    frame_i = 1'b1; step(1); frame_i = 1'b0;
    step(2);
    set_ch(1, 32'd80);
    exp_q.push_back(32'd30);
    frame_i = 1'b1; capture_i = 1'b1; step(1); frame_i = 1'b0; capture_i = 1'b0;
    step(4);
    set_ch(1, 32'd90);
    exp_q.push_back(32'd10);
    pulse_capture(cap_e);
    step(4);
    pulse_disarm();
    wait_idle("diff", 20);

    // List saturation at 64 entries and list writes ignored while active
    clear_list();
    for (int k = 0; k < 64; k++) wr(k % 32, 0);
    wr(7, 0);
    for (int n = 0; n < NCHAN; n++) set_ch(n, 32'(32'hA000 + n));
    pulse_arm(arm_e);
    clear_list();
    wr(5, 0);
    for (int k = 0; k < 64; k++) exp_q.push_back(32'(32'hA000 + (k % 32)));
    pulse_capture(cap_e);
    step(70);
    check("list64 drained", 64'(exp_q.size()), 64'd0);
    pulse_disarm();
    wait_idle("list", 20);

    // Reset in the middle of serialisation
    pulse_arm(arm_e);
    for (int k = 0; k < 64; k++) exp_q.push_back(32'(32'hA000 + (k % 32)));
    pulse_capture(cap_e);
    step(5);
    reset_i = 1'b1;
    exp_q.delete();
    #1;
    check("mid rst dat", 64'(pcap_dat_o), 64'd0);
    check("mid rst valid", 64'(pcap_dat_valid_o), 64'd0);
    check("mid rst actv", 64'(pcap_actv_o), 64'd0);
    check("mid rst health", 64'(HEALTH), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("mid rst no done", 64'(pcap_done_o), 64'd0);
    end
    reset_i = 1'b0;
    step(2);
    check("post rst no done", 64'(pcap_done_o), 64'd0);

    // Clean re-ARM, stop by enable falling edge, then DISARM in IDLE
    wr(2, 0);
    set_ch(2, 32'h222);
    pulse_arm(arm_e);
    exp_q.push_back(32'h222);
    pulse_capture(cap_e);
    step(4);
    enable_i = 1'b0;
    step(1);
    wait_idle("enfall", 20);
    check("enfall health", 64'(HEALTH), 64'd0);
    enable_i = 1'b1;
    step(2);
    pulse_disarm();
    step(1);
    check("idle disarm health", 64'(HEALTH), 64'd0);
    check("idle disarm actv", 64'(pcap_actv_o), 64'd0);

    step(2);
    check("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
